// File: rtl/reservoir_pkg.sv
// Shared helpers for the reservoir level controller: width derivations and
// sensor-vector decoding (thermometer check, population count).
package reservoir_pkg;

  localparam int VEC_MAX = 32;

  function automatic int level_width(input int n_sensors);
    return $clog2(n_sensors + 1);
  endfunction

  function automatic int alarm_width(input int alarm_cycles);
    return $clog2(alarm_cycles + 1);
  endfunction

  function automatic int unsigned popcount(input logic [VEC_MAX-1:0] vec);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < VEC_MAX; i++) cnt += vec[i] ? 1 : 0;
    return cnt;
  endfunction

  // A valid code is a contiguous run of ones from bit 0, i.e. 2^L-1.
  function automatic logic is_thermo(input logic [VEC_MAX-1:0] vec);
    return (vec & (vec + 32'd1)) == '0;
  endfunction

endpackage

// File: rtl/reservoir_ctrl_n_debounce.sv
// Accepts a sensor vector once it has been sampled DEBOUNCE consecutive edges;
// the run saturates so a held vector is accepted only once.
module sensor_debounce #(
  parameter int W        = 3,
  parameter int DEBOUNCE = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         accept_pulse
);

  localparam int            CW      = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] RUN_MAX = CW'(DEBOUNCE);

  logic [W-1:0]  r_cand;
  logic [CW-1:0] r_run;
  logic          w_same;
  logic [CW-1:0] w_run_next;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_same     = (d == r_cand) && (r_run != '0);
    w_run_next = CW'(1);
    if (w_same) w_run_next = (r_run == RUN_MAX) ? RUN_MAX : r_run + 1'b1;
    accept_pulse = (w_run_next == RUN_MAX) && !(w_same && (r_run == RUN_MAX));
  end

  assign q = d;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cand <= '0;
      r_run  <= '0;
    end else begin
      r_cand <= d;
      r_run  <= w_run_next;
    end
  end

endmodule

// File: rtl/reservoir_ctrl_n.sv
// Reservoir level controller: debounced stacked sensors drive N nominal valves,
// a supplemental valve, a fault flag for non-thermometer vectors and an empty alarm.
module reservoir_ctrl_n
  import reservoir_pkg::*;
#(
  parameter  int N_SENSORS    = 3,
  parameter  int DEBOUNCE     = 2,
  parameter  int ALARM_CYCLES = 8,
  localparam int LW           = level_width(N_SENSORS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_SENSORS-1:0] s,
  output logic [N_SENSORS-1:0] fr,
  output logic                 dfr,
  output logic [LW-1:0]        level,
  output logic [LW-1:0]        last_level,
  output logic                 level_chg,
  output logic                 sensor_fault,
  output logic                 empty_alarm
);

  localparam int            AW        = alarm_width(ALARM_CYCLES);
  localparam logic [AW-1:0] ALARM_MAX = AW'(ALARM_CYCLES);
  localparam logic [LW-1:0] FULL      = LW'(N_SENSORS);

  logic [N_SENSORS-1:0] w_vec;
  logic                 w_accept;
  logic                 w_valid;
  logic [LW-1:0]        w_new_level;
  logic [N_SENSORS-1:0] w_fr_next;

  logic [LW-1:0]        r_level;
  logic [LW-1:0]        r_last_level;
  logic [N_SENSORS-1:0] r_fr;
  logic                 r_dfr;
  logic                 r_level_chg;
  logic                 r_fault;
  logic [AW-1:0]        r_alarm_cnt;

  sensor_debounce #(.W(N_SENSORS), .DEBOUNCE(DEBOUNCE)) u_debounce (
    .clk         (clk),
    .rst         (rst),
    .d           (s),
    .q           (w_vec),
    .accept_pulse(w_accept)
  );

  // Valve k stays open while the level is at or below its own threshold.
  always_comb begin
    w_valid     = is_thermo(VEC_MAX'(w_vec));
    w_new_level = LW'(popcount(VEC_MAX'(w_vec)));
    w_fr_next   = '0;
    for (int k = 0; k < N_SENSORS; k++)
      w_fr_next[k] = (int'(w_new_level) <= N_SENSORS - 1 - k);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_level      <= '0;
      r_last_level <= '0;
      r_fr         <= '1;
      r_dfr        <= 1'b1;
      r_level_chg  <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_level_chg <= 1'b0;
      if (w_accept) begin
        if (!w_valid) begin
          r_fault <= 1'b1;
        end else begin
          r_fault <= 1'b0;
          if (w_new_level != r_level) begin
            r_level      <= w_new_level;
            r_last_level <= r_level;
            r_level_chg  <= 1'b1;
            r_fr         <= w_fr_next;
            r_dfr        <= (w_new_level < r_level) && (w_new_level != FULL);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                     r_alarm_cnt <= '0;
    else if (r_level != '0)      r_alarm_cnt <= '0;
    else if (r_alarm_cnt != ALARM_MAX) r_alarm_cnt <= r_alarm_cnt + 1'b1;
  end

  assign level        = r_level;
  assign last_level   = r_last_level;
  assign fr           = r_fr;
  assign dfr          = r_dfr;
  assign level_chg    = r_level_chg;
  assign sensor_fault = r_fault;
  assign empty_alarm  = (r_alarm_cnt == ALARM_MAX);

endmodule

// File: tb/tb_reservoir_ctrl_n.sv
// Bench for reservoir_ctrl_n: directed vector table for the documented scenarios,
// then randomized stimulus against a behavioural model.
module tb_reservoir_ctrl_n;

  localparam int N   = 3;
  localparam int DEB = 2;
  localparam int AC  = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] s   = '0;
  logic [N-1:0] fr;
  logic         dfr;
  logic [1:0]   level;
  logic [1:0]   last_level;
  logic         level_chg;
  logic         sensor_fault;
  logic         empty_alarm;

  int n_checks = 0;
  int n_fail   = 0;

  reservoir_ctrl_n #(.N_SENSORS(N), .DEBOUNCE(DEB), .ALARM_CYCLES(AC)) dut (
    .clk         (clk),
    .rst         (rst),
    .s           (s),
    .fr          (fr),
    .dfr         (dfr),
    .level       (level),
    .last_level  (last_level),
    .level_chg   (level_chg),
    .sensor_fault(sensor_fault),
    .empty_alarm (empty_alarm)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [2:0] s;
    logic [1:0] level;
    logic [1:0] last;
    logic [2:0] fr;
    logic       dfr;
    logic       chg;
    logic       fault;
    logic       alarm;
  } vec_t;

  vec_t tbl[33];

  // Behavioural model state
  int         m_run;
  bit         m_have;
  logic [2:0] m_prev;
  int         m_level, m_last, m_acnt;
  bit         m_dfr, m_chg, m_fault;

  function automatic vec_t mk(input logic r, input logic [2:0] sv, input logic [1:0] lv,
                              input logic [1:0] ll, input logic [2:0] f, input logic d,
                              input logic c, input logic flt, input logic al);
    vec_t v;
    v.rst = r; v.s = sv; v.level = lv; v.last = ll; v.fr = f;
    v.dfr = d; v.chg = c; v.fault = flt; v.alarm = al;
    return v;
  endfunction

  function automatic logic [10:0] dut_out();
    return {level, last_level, fr, dfr, level_chg, sensor_fault, empty_alarm};
  endfunction

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {lvl,last,fr,dfr,chg,flt,alm}=%b required %b", name, act, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic [2:0] sv);
    int l;
    if (r) begin
      m_level = 0; m_last = 0; m_dfr = 1; m_chg = 0; m_fault = 0; m_acnt = 0;
      m_have = 0; m_run = 0;
      return;
    end
    m_acnt = (m_level == 0) ? ((m_acnt < AC) ? m_acnt + 1 : AC) : 0;
    m_chg  = 0;
    m_run  = (m_have && sv == m_prev) ? ((m_run > DEB) ? m_run : m_run + 1) : 1;
    m_prev = sv;
    m_have = 1;
    if (m_run == DEB) begin
      l = $countones(sv);
      if (int'(sv) != (1 << l) - 1) begin
        m_fault = 1;
      end else begin
        m_fault = 0;
        if (l != m_level) begin
          m_dfr   = (l < m_level) && (l != N);
          m_last  = m_level;
          m_level = l;
          m_chg   = 1;
        end
      end
    end
  endtask

  function automatic logic [10:0] model_out();
    logic [2:0] f;
    for (int k = 0; k < N; k++) f[k] = (m_level <= N - 1 - k);
    return {2'(m_level), 2'(m_last), f, m_dfr, m_chg, m_fault, (m_acnt == AC)};
  endfunction

  task automatic step(input logic r, input logic [2:0] sv);
    rst = r;
    s   = sv;
    @(posedge clk);
    model_edge(r, sv);
    #1;
  endtask

  initial begin
    logic [2:0] sv;
    logic       r;
    // rst   s       lvl   last  fr      dfr chg flt alm
    tbl[0]  = mk(1, 3'b000, 2'd0, 2'd0, 3'b111, 1, 0, 0, 0);
    tbl[1]  = mk(1, 3'b000, 2'd0, 2'd0, 3'b111, 1, 0, 0, 0);
    for (int i = 2; i < 9; i++) tbl[i] = mk(0, 3'b000, 2'd0, 2'd0, 3'b111, 1, 0, 0, 0);
    tbl[9]  = mk(0, 3'b000, 2'd0, 2'd0, 3'b111, 1, 0, 0, 1);
    tbl[10] = mk(0, 3'b001, 2'd0, 2'd0, 3'b111, 1, 0, 0, 1);
    tbl[11] = mk(0, 3'b001, 2'd1, 2'd0, 3'b011, 0, 1, 0, 1);
    tbl[12] = mk(0, 3'b011, 2'd1, 2'd0, 3'b011, 0, 0, 0, 0);
    tbl[13] = mk(0, 3'b011, 2'd2, 2'd1, 3'b001, 0, 1, 0, 0);
    tbl[14] = mk(0, 3'b111, 2'd2, 2'd1, 3'b001, 0, 0, 0, 0);
    tbl[15] = mk(0, 3'b111, 2'd3, 2'd2, 3'b000, 0, 1, 0, 0);
    tbl[16] = mk(0, 3'b011, 2'd3, 2'd2, 3'b000, 0, 0, 0, 0);
    tbl[17] = mk(0, 3'b011, 2'd2, 2'd3, 3'b001, 1, 1, 0, 0);
    tbl[18] = mk(0, 3'b111, 2'd2, 2'd3, 3'b001, 1, 0, 0, 0);
    tbl[19] = mk(0, 3'b111, 2'd3, 2'd2, 3'b000, 0, 1, 0, 0);
    tbl[20] = mk(0, 3'b001, 2'd3, 2'd2, 3'b000, 0, 0, 0, 0);
    tbl[21] = mk(0, 3'b001, 2'd1, 2'd3, 3'b011, 1, 1, 0, 0);
    tbl[22] = mk(0, 3'b011, 2'd1, 2'd3, 3'b011, 1, 0, 0, 0);
    tbl[23] = mk(0, 3'b001, 2'd1, 2'd3, 3'b011, 1, 0, 0, 0);
    tbl[24] = mk(0, 3'b001, 2'd1, 2'd3, 3'b011, 1, 0, 0, 0);
    tbl[25] = mk(0, 3'b101, 2'd1, 2'd3, 3'b011, 1, 0, 0, 0);
    tbl[26] = mk(0, 3'b101, 2'd1, 2'd3, 3'b011, 1, 0, 1, 0);
    tbl[27] = mk(0, 3'b011, 2'd1, 2'd3, 3'b011, 1, 0, 1, 0);
    tbl[28] = mk(0, 3'b011, 2'd2, 2'd1, 3'b001, 0, 1, 0, 0);
    tbl[29] = mk(0, 3'b111, 2'd2, 2'd1, 3'b001, 0, 0, 0, 0);
    tbl[30] = mk(1, 3'b111, 2'd0, 2'd0, 3'b111, 1, 0, 0, 0);
    tbl[31] = mk(0, 3'b111, 2'd0, 2'd0, 3'b111, 1, 0, 0, 0);
    tbl[32] = mk(0, 3'b111, 2'd3, 2'd0, 3'b000, 0, 1, 0, 0);

    for (int i = 0; i < 33; i++) begin
      step(tbl[i].rst, tbl[i].s);
      check($sformatf("vec%0d", i), dut_out(),
            {tbl[i].level, tbl[i].last, tbl[i].fr, tbl[i].dfr,
             tbl[i].chg, tbl[i].fault, tbl[i].alarm});
    end

    // Long empty hold then fill: alarm saturates, clears one edge after level leaves 0.
    step(1, 3'b000);
    for (int i = 0; i < 12; i++) step(0, 3'b000);
    check("alarm_saturated", dut_out(), model_out());
    step(0, 3'b001);
    step(0, 3'b001);
    check("alarm_hold_on_fill", {10'd0, empty_alarm}, 11'd1);
    step(0, 3'b001);
    check("alarm_clear_after_fill", {10'd0, empty_alarm}, 11'd0);

    // Randomized stimulus against the model.
    sv = 3'b000;
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 9) < 8) sv = 3'((1 << $urandom_range(0, 3)) - 1);
        else                          sv = 3'($urandom_range(0, 7));
      end
      step(r, sv);
      check($sformatf("rand%0d", i), dut_out(), model_out());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
